rom_car_sprite: RTL and testbench

ROM_CAR_SPRITE -- requirements
Module: rom_car

---
 rtl/rom_car_sprite.sv | 93 +++++++++
 tb/tb_rom_car_sprite.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rom_car_sprite.sv
// rtl/rom_car_sprite.sv - procedurally decoded 80x121 car sprite ROM with a registered pixel copy
//
// The sprite is drawn from rectangle tests on (row, col) rather than from a
// stored table, so there is no memory initialisation file to maintain.
// data_pix is purely combinational; data_q is the only state in the block.

module rom_car_sprite (
  input  logic [13:0] address,
  output logic [2:0]  data_pix,
  input  logic        logic_clk,
  input  logic        reset,
  output logic [2:0]  data_q
);

  // Colour codes: bit0 = R, bit1 = G, bit2 = B
  localparam logic [2:0] C_BACKGROUND = 3'b000;
  localparam logic [2:0] C_BODY       = 3'b001;
  localparam logic [2:0] C_HEADLIGHT  = 3'b011;
  localparam logic [2:0] C_WINDOW     = 3'b100;
  localparam logic [2:0] C_WHITE      = 3'b111;

  // Sprite geometry
  localparam logic [13:0] SPRITE_COLS    = 14'd80;
  localparam logic [13:0] SPRITE_ENTRIES = 14'd9680;

  logic [13:0] w_row;
  logic [13:0] w_col;
  logic        w_in_range;
  logic        w_headlight;
  logic        w_window;
  logic        w_stripe;
  logic        w_body;
  logic        w_tyre;

  // Linear index to row/column; constant divisor keeps this a fixed decoder
  always_comb begin
    w_row = address / SPRITE_COLS;
    w_col = address % SPRITE_COLS;
  end

  // Region membership, all bounds inclusive at both ends
  always_comb begin
    w_in_range  = (address < SPRITE_ENTRIES);

    w_headlight = (w_row <= 14'd4) &&
                  (((w_col >= 14'd15) && (w_col <= 14'd24)) ||
                   ((w_col >= 14'd55) && (w_col <= 14'd64)));

    w_window    = (w_col >= 14'd20) && (w_col <= 14'd59) &&
                  (((w_row >= 14'd30) && (w_row <= 14'd44)) ||
                   ((w_row >= 14'd85) && (w_row <= 14'd94)));

    w_stripe    = (w_col >= 14'd37) && (w_col <= 14'd42) &&
                  (w_row >= 14'd45) && (w_row <= 14'd84);

    w_body      = (w_col >= 14'd10) && (w_col <= 14'd69);

    w_tyre      = ((w_col <= 14'd9) ||
                   ((w_col >= 14'd70) && (w_col <= 14'd79))) &&
                  (((w_row >= 14'd15) && (w_row <= 14'd39)) ||
                   ((w_row >= 14'd80) && (w_row <= 14'd104)));
  end

  // Priority select: out-of-range, headlight, window, stripe, body, tyre, background
  always_comb begin
    data_pix = C_BACKGROUND;
    if (!w_in_range) begin
      data_pix = C_BACKGROUND;
    end else if (w_headlight) begin
      data_pix = C_HEADLIGHT;
    end else if (w_window) begin
      data_pix = C_WINDOW;
    end else if (w_stripe) begin
      data_pix = C_WHITE;
    end else if (w_body) begin
      data_pix = C_BODY;
    end else if (w_tyre) begin
      data_pix = C_WHITE;
    end else begin
      data_pix = C_BACKGROUND;
    end
  end

  // Registered pixel copy; reset wins over loading
  always_ff @(posedge logic_clk) begin
    if (reset) begin
      data_q <= C_BACKGROUND;
    end else begin
      data_q <= data_pix;
    end
  end

endmodule

// File: tb/tb_rom_car_sprite.sv
// tb/tb_rom_car_sprite.sv - directed and sweep checks for rom_car_sprite

module tb_rom_car_sprite;

  logic [13:0] address;
  logic [2:0]  data_pix;
  logic        logic_clk;
  logic        reset;
  logic [2:0]  data_q;

  int n_checks;
  int n_fails;

  rom_car_sprite dut (
    .address   (address),
    .data_pix  (data_pix),
    .logic_clk (logic_clk),
    .reset     (reset),
    .data_q    (data_q)
  );

  initial logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference colour from row/col following the documented region table
  function automatic logic [2:0] ref_pix(input int row, input int col);
    bit tyre_c, tyre_r, head, win, strp, body;
    head   = (row <= 4) && ((col >= 15 && col <= 24) || (col >= 55 && col <= 64));
    win    = (col >= 20 && col <= 59) && ((row >= 30 && row <= 44) || (row >= 85 && row <= 94));
    strp   = (col >= 37 && col <= 42) && (row >= 45 && row <= 84);
    body   = (col >= 10 && col <= 69);
    tyre_c = (col <= 9) || (col >= 70);
    tyre_r = (row >= 15 && row <= 39) || (row >= 80 && row <= 104);
    if (head)                 return 3'b011;
    else if (win)             return 3'b100;
    else if (strp)            return 3'b111;
    else if (body)            return 3'b001;
    else if (tyre_c && tyre_r) return 3'b111;
    else                      return 3'b000;
  endfunction

  typedef struct {
    int         addr;
    logic [2:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int sweep_errs;
    int first_bad;
    n_checks = 0;
    n_fails  = 0;

    vecs.push_back('{0,     3'b000, "pix_a0"});
    vecs.push_back('{15,    3'b011, "pix_a15_headlight"});
    vecs.push_back('{64,    3'b011, "pix_a64_headlight_edge"});
    vecs.push_back('{65,    3'b001, "pix_a65_body"});
    vecs.push_back('{2420,  3'b100, "pix_a2420_windscreen"});
    vecs.push_back('{2419,  3'b001, "pix_a2419_body"});
    vecs.push_back('{7220,  3'b100, "pix_a7220_rear_window"});
    vecs.push_back('{1605,  3'b111, "pix_a1605_tyre"});
    vecs.push_back('{1200,  3'b111, "pix_a1200_tyre_edge"});
    vecs.push_back('{1120,  3'b000, "pix_a1120_bg"});
    vecs.push_back('{3279,  3'b000, "pix_a3279_bg"});
    vecs.push_back('{4840,  3'b111, "pix_a4840_stripe"});
    vecs.push_back('{4812,  3'b001, "pix_a4812_body"});
    vecs.push_back('{9679,  3'b000, "pix_a9679_last"});
    vecs.push_back('{9620,  3'b001, "pix_a9620_body"});
    vecs.push_back('{9680,  3'b000, "pix_a9680_oor"});
    vecs.push_back('{16383, 3'b000, "pix_a16383_oor"});
    vecs.push_back('{8399,  3'b111, "pix_a8399_rear_tyre_r104"});
    vecs.push_back('{8479,  3'b000, "pix_a8479_bg_r105"});

    // Reset state of the register
    reset   = 1'b1;
    address = 14'd0;
    @(posedge logic_clk);
    #1;
    check("q_after_reset", int'(data_q), 0);

    // Directed combinational vectors
    foreach (vecs[i]) begin
      address = vecs[i].addr[13:0];
      #1;
      check(vecs[i].tag, int'(data_pix), int'(vecs[i].exp));
    end

    // Full sweep against the reference model
    sweep_errs = 0;
    first_bad  = -1;
    for (int r = 0; r < 121; r++) begin
      for (int c = 0; c < 80; c++) begin
        int a;
        a = r * 80 + c;
        address = a[13:0];
        #1;
        if (data_pix !== ref_pix(r, c)) begin
          sweep_errs++;
          if (first_bad < 0) first_bad = a;
        end
      end
    end
    check("sweep_mismatch_count", sweep_errs, 0);
    check("sweep_first_bad_addr", first_bad, -1);

    // Register path: release reset and load headlight
    @(negedge logic_clk);
    reset   = 1'b0;
    address = 14'd15;
    @(posedge logic_clk);
    #1;
    check("q_load_a15", int'(data_q), 3);

    // Reset again while addressing a lit pixel
    @(negedge logic_clk);
    reset = 1'b1;
    @(posedge logic_clk);
    #1;
    check("q_reset_priority", int'(data_q), 0);
    check("pix_during_reset", int'(data_pix), 3);

    // First edge with reset low loads current pixel
    @(negedge logic_clk);
    reset   = 1'b0;
    address = 14'd2420;
    @(posedge logic_clk);
    #1;
    check("q_load_a2420", int'(data_q), 4);

    // Follows address one cycle later
    @(negedge logic_clk);
    address = 14'd65;
    #1;
    check("q_holds_before_edge", int'(data_q), 4);
    @(posedge logic_clk);
    #1;
    check("q_load_a65", int'(data_q), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
